// File: rtl/decode_pkg.sv
// Shared RV32I/RV64I decode constants: major opcodes, format codes, and
// immediate-format selectors used by the decode stage and imm_gen.
package decode_pkg;

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    IT_R   = 3'd0,
    IT_I   = 3'd1,
    IT_S   = 3'd2,
    IT_B   = 3'd3,
    IT_U   = 3'd4,
    IT_J   = 3'd5,
    IT_ILL = 3'd7
  } inst_type_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

endpackage

// File: rtl/decode_imm_gen.sv
// Combinational immediate generator: builds the 32-bit immediate for the
// selected format and sign-extends it to XLEN.
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (fmt)
      IMM_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm32 = {inst[31:12], 12'b0};
      IMM_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I/RV64I decode stage with valid/ready on both sides and an
// optional skid register so inReady comes straight from a flop.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            inValid,
  output logic            inReady,
  input  logic [31:0]     instIn,
  input  logic [XLEN-1:0] pcIn,
  output logic            outValid,
  input  logic            outReady,
  output logic [XLEN-1:0] pcOut,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      fn3,
  output logic [6:0]      fn7,
  output logic [XLEN-1:0] imm,
  output inst_type_e      instType,
  output logic            illegal
);

  // Bundle layout: {illegal, type, imm, pc, raw inst}
  localparam int BW = 1 + 3 + 2*XLEN + 32;
  // Shift upper-bit check: RV64 has a 6-bit shamt so only inst[31:26] count.
  localparam logic [6:0] SRA_UPPER = (XLEN == 64) ? 7'b0010000 : 7'b0100000;

  inst_type_e      dec_type;
  imm_fmt_e        dec_fmt;
  logic [6:0]      upper;
  logic [XLEN-1:0] dec_imm;
  logic [BW-1:0]   dec_bundle;

  always_comb begin
    dec_type = IT_ILL;
    dec_fmt  = IMM_NONE;
    upper    = (XLEN == 64) ? {1'b0, instIn[31:26]} : instIn[31:25];
    case (instIn[6:0])
      OP_OP: begin
        dec_type = IT_R;
        if (!(instIn[31:25] == 7'b0 ||
              (instIn[31:25] == 7'b0100000 &&
               (instIn[14:12] == 3'b000 || instIn[14:12] == 3'b101))))
          dec_type = IT_ILL;
      end
      OP_OP_IMM: begin
        dec_type = IT_I;
        dec_fmt  = IMM_I;
        if (instIn[14:12] == 3'b001 && upper != 7'b0)
          dec_type = IT_ILL;
        if (instIn[14:12] == 3'b101 && upper != 7'b0 && upper != SRA_UPPER)
          dec_type = IT_ILL;
      end
      OP_LOAD, OP_JALR, OP_SYSTEM, OP_MISC_MEM: begin
        dec_type = IT_I;
        dec_fmt  = IMM_I;
      end
      OP_STORE:         begin dec_type = IT_S; dec_fmt = IMM_S; end
      OP_BRANCH:        begin dec_type = IT_B; dec_fmt = IMM_B; end
      OP_LUI, OP_AUIPC: begin dec_type = IT_U; dec_fmt = IMM_U; end
      OP_JAL:           begin dec_type = IT_J; dec_fmt = IMM_J; end
      default:          dec_type = IT_ILL;
    endcase
    if (instIn[1:0] != 2'b11) dec_type = IT_ILL;
    if (dec_type == IT_ILL)   dec_fmt  = IMM_NONE;
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst (instIn),
    .fmt  (dec_fmt),
    .imm  (dec_imm)
  );

  assign dec_bundle = {(dec_type == IT_ILL), dec_type, dec_imm, pcIn, instIn};

  logic          out_valid_q, out_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic [BW-1:0] out_q, out_d;
  logic [BW-1:0] skid_q, skid_d;
  logic          accept, out_fire;

  generate
    if (SKID != 0) begin : g_skid
      assign inReady = !skid_valid_q;
    end else begin : g_noskid
      assign inReady = !out_valid_q || outReady;
    end
  endgenerate

  assign accept   = inValid && inReady;
  assign out_fire = out_valid_q && outReady;

  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_d        = out_q;
    skid_d       = skid_q;
    if (!out_valid_q || out_fire) begin
      // Output slot frees up: the older skid entry always goes first.
      out_valid_d = skid_valid_q || accept;
      if (skid_valid_q) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d = dec_bundle;
      end
    end else if (accept && SKID != 0) begin
      skid_d       = dec_bundle;
      skid_valid_d = 1'b1;
    end
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_q        <= out_d;
      skid_q       <= skid_d;
    end
  end

  logic [2:0]  out_type;
  logic [31:0] out_inst;

  assign {illegal, out_type, imm, pcOut, out_inst} = out_q;
  assign instType = inst_type_e'(out_type);
  assign outValid = out_valid_q;
  assign opcode   = out_inst[6:0];
  assign rd       = out_inst[11:7];
  assign fn3      = out_inst[14:12];
  assign rs1      = out_inst[19:15];
  assign rs2      = out_inst[24:20];
  assign fn7      = out_inst[31:25];

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: an XLEN=32 SKID=1 instance plus an XLEN=64
// instance fed the same stream for the RV64 immediate/shamt cases.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] inst_in = '0;
  logic [31:0] pc_in = '0;
  logic [63:0] pc_in64;

  logic        in_ready, out_valid, ill;
  logic [31:0] pc_out, imm;
  logic [6:0]  opcode, fn7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  fn3;
  inst_type_e  ityp;

  logic        in_ready64, out_valid64, ill64;
  logic [63:0] pc_out64, imm64;
  logic [6:0]  opcode64, fn7_64;
  logic [4:0]  rd64, rs1_64, rs2_64;
  logic [2:0]  fn3_64;
  inst_type_e  ityp64;

  int checks = 0;
  int errors = 0;

  assign pc_in64 = {32'h0, pc_in};
  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .SKID(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .inValid(in_valid), .inReady(in_ready),
    .instIn(inst_in), .pcIn(pc_in), .outValid(out_valid), .outReady(out_ready),
    .pcOut(pc_out), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .fn3(fn3),
    .fn7(fn7), .imm(imm), .instType(ityp), .illegal(ill)
  );

  decode_stage #(.XLEN(64), .SKID(1)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .inValid(in_valid), .inReady(in_ready64),
    .instIn(inst_in), .pcIn(pc_in64), .outValid(out_valid64), .outReady(out_ready),
    .pcOut(pc_out64), .opcode(opcode64), .rd(rd64), .rs1(rs1_64), .rs2(rs2_64), .fn3(fn3_64),
    .fn7(fn7_64), .imm(imm64), .instType(ityp64), .illegal(ill64)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dec(input string tag, input logic [2:0] t, input logic [31:0] im,
                         input logic il, input logic [31:0] pc);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".type"},  32'(ityp), 32'(t));
    chk({tag, ".imm"},   imm, im);
    chk({tag, ".ill"},   32'(ill), 32'(il));
    chk({tag, ".pc"},    pc_out, pc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] pc);
    in_valid = 1'b1;
    inst_in  = i;
    pc_in    = pc;
  endtask

  initial begin
    #12 rst = 1'b0;
    #1;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.ready", 32'(in_ready), 32'd1);
    chk("rst.type",  32'(ityp), 32'd0);
    chk("rst.imm",   imm, 32'd0);
    chk("rst.ill",   32'(ill), 32'd0);

    // Streaming with outReady=1: each bundle shows up one edge after accept.
    drive(32'h00848933, 32'h1000); step();
    chk_dec("add", 3'd0, 32'h0, 1'b0, 32'h1000);
    chk("add.rd", 32'(rd), 32'd18); chk("add.rs1", 32'(rs1), 32'd9); chk("add.rs2", 32'(rs2), 32'd8);
    drive(32'h10100493, 32'h1004); step();
    chk_dec("addi", 3'd1, 32'h101, 1'b0, 32'h1004);
    chk("addi.rd", 32'(rd), 32'd9);
    drive(32'h0082a223, 32'h1008); step();
    chk_dec("sw", 3'd2, 32'h4, 1'b0, 32'h1008);
    chk("sw.rs1", 32'(rs1), 32'd5); chk("sw.rs2", 32'(rs2), 32'd8);
    drive(32'h014c6463, 32'h100c); step();
    chk_dec("bltu", 3'd3, 32'h8, 1'b0, 32'h100c);
    chk("bltu.rs1", 32'(rs1), 32'd24); chk("bltu.rs2", 32'(rs2), 32'd20); chk("bltu.fn3", 32'(fn3), 32'd6);
    drive(32'h7ff080e7, 32'h1010); step();
    chk_dec("jalr", 3'd1, 32'h7ff, 1'b0, 32'h1010);
    drive(32'h0000006f, 32'h1014); step();
    chk_dec("jal", 3'd5, 32'h0, 1'b0, 32'h1014);
    drive(32'h872370b7, 32'h1018); step();
    chk_dec("lui", 3'd4, 32'h87237000, 1'b0, 32'h1018);
    chk64("lui.imm64", imm64, 64'hFFFFFFFF87237000);
    drive(32'h10000917, 32'h101c); step();
    chk_dec("auipc", 3'd4, 32'h10000000, 1'b0, 32'h101c);
    drive(32'h41425313, 32'h1020); step();
    chk_dec("srai", 3'd1, 32'h414, 1'b0, 32'h1020);
    chk("srai.rd", 32'(rd), 32'd6); chk("srai.rs1", 32'(rs1), 32'd4);
    chk("srai.ill64", 32'(ill64), 32'd0);
    drive(32'h02000033, 32'h1024); step();
    chk_dec("mul", 3'd7, 32'h0, 1'b1, 32'h1024);
    drive(32'h00000010, 32'h1028); step();
    chk_dec("lowbits", 3'd7, 32'h0, 1'b1, 32'h1028);
    // srli shamt=37: legal only with the RV64 6-bit shamt
    drive(32'h0250d093, 32'h102c); step();
    chk_dec("srli37", 3'd7, 32'h0, 1'b1, 32'h102c);
    chk("srli37.ill64", 32'(ill64), 32'd0);
    chk("srli37.type64", 32'(ityp64), 32'd1);
    chk64("srli37.imm64", imm64, 64'h25);
    in_valid = 1'b0; step();
    chk("drain.valid", 32'(out_valid), 32'd0);

    // Backpressure: A in output, B in skid, C held off.
    out_ready = 1'b0;
    drive(32'h00000013, 32'h200); step();
    chk("bp.a.pc", pc_out, 32'h200); chk("bp.a.ready", 32'(in_ready), 32'd1);
    drive(32'h00100093, 32'h204); step();
    chk("bp.b.pc", pc_out, 32'h200); chk("bp.b.ready", 32'(in_ready), 32'd0);
    drive(32'h00200113, 32'h208); step();
    chk("bp.c.pc", pc_out, 32'h200); chk("bp.c.ready", 32'(in_ready), 32'd0);
    chk("bp.c.valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1; step();
    chk("bp.out_b.pc", pc_out, 32'h204); chk("bp.out_b.imm", imm, 32'd1);
    chk("bp.out_b.ready", 32'(in_ready), 32'd1);
    step();
    chk("bp.out_c.pc", pc_out, 32'h208); chk("bp.out_c.imm", imm, 32'd2);
    chk("bp.out_c.valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0; step();
    chk("bp.end.valid", 32'(out_valid), 32'd0);

    // Flush with A and B held, C presented alongside.
    out_ready = 1'b0;
    drive(32'h00000013, 32'h300); step();
    drive(32'h00100093, 32'h304); step();
    drive(32'h00200113, 32'h308); flush = 1'b1; step();
    chk("fl.valid", 32'(out_valid), 32'd0); chk("fl.ready", 32'(in_ready), 32'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
    chk("fl.after1.valid", 32'(out_valid), 32'd0);
    step();
    chk("fl.after2.valid", 32'(out_valid), 32'd0);
    // Flush beats a same-cycle accept.
    drive(32'h00300193, 32'h30c); flush = 1'b1; step();
    chk("fl.acc.valid", 32'(out_valid), 32'd0);
    flush = 1'b0; in_valid = 1'b0; step();
    chk("fl.acc.after.valid", 32'(out_valid), 32'd0);

    // Async reset in the middle of a stall, away from any clock edge.
    out_ready = 1'b0;
    drive(32'h00500093, 32'h400); step();
    in_valid = 1'b0;
    chk("ar.pre.valid", 32'(out_valid), 32'd1); chk("ar.pre.pc", pc_out, 32'h400);
    #3 rst = 1'b1;
    #1;
    chk("ar.valid", 32'(out_valid), 32'd0); chk("ar.pc", pc_out, 32'h0);
    chk("ar.imm", imm, 32'h0); chk("ar.rd", 32'(rd), 32'd0);
    chk("ar.type", 32'(ityp), 32'd0); chk("ar.ready", 32'(in_ready), 32'd1);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    out_ready = 1'b1;
    drive(32'h10100493, 32'h500); step();
    chk_dec("ar.addi", 3'd1, 32'h101, 1'b0, 32'h500);
    chk("ar.addi.rd", 32'(rd), 32'd9);
    in_valid = 1'b0; step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered RV32I/RV64I instruction decode stage sitting between the fetch and execute pipeline registers. It extracts instruction fields, generates the sign-extended immediate, classifies the format, and flags illegal encodings. It is the pipelined, handshaked, XLEN-generic successor to the combinational field decoder. It uses valid/ready handshakes on both sides and an optional skid buffer to break the ready path.

Parameters:
XLEN, 32, datapath width (32 or 64); sets immediate/PC width and shamt rules
SKID, 1, 1 = two-entry (output reg + skid reg), inReady registered; 0 = single output reg, inReady = !outValid | outReady

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
flush  input  1  discard all held instructions
inValid  input  1  upstream instruction valid
inReady  output  1  stage can accept
instIn  input  32  raw instruction
pcIn  input  XLEN  instruction PC
outValid  output  1  decoded bundle valid
outReady  input  1  downstream accepts
pcOut  output  XLEN  PC of bundle
opcode  output  7  inst[6:0]
rd  output  5  inst[11:7]
rs1  output  5  inst[19:15]
rs2  output  5  inst[24:20]
fn3  output  3  inst[14:12]
fn7  output  7  inst[31:25]
imm  output  XLEN  sign-extended immediate
instType  output  3  format code (package enum)
illegal  output  1  illegal encoding

Behaviour:
- Reset (async, active-high): outValid=0, skid empty, all bundle outputs 0, instType=R (0), illegal=0. inReady=1 while rst is low after reset.
- Accept on inValid&&inReady. Latency: 1 cycle from accept to outValid.
- Bundle is stable while outValid && !outReady. Transfer on outValid&&outReady.
- SKID=1: inReady = !skidValid (registered). If the accept happens while output is stalled, the decoded bundle goes to the skid reg. On output transfer, skid moves to the output reg. Order is always preserved.
- SKID=0: no skid reg. Accept while stalled is impossible by the inReady definition.
- Simultaneous output transfer and input accept with skid empty: the new bundle loads the output reg and outValid stays 1.
- flush: at the next edge, outValid=0 and skid is cleared. It has priority over a same-cycle accept, so the input is accepted and dropped. inReady=1 the cycle after a flush.
- Fields rd/rs1/rs2/fn3/fn7 are passed raw regardless of format.
- Immediates, sign bit inst[31]:
  - I: inst[31:20]
  - S: {inst[31:25],inst[11:7]}
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],0}
  - U: {inst[31:12],12'b0}, sign-extended to XLEN
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],0}
  - R/illegal: 0
- instType: R=0 (0110011); I=1 (0010011, 0000011, 1100111, 1110011, 0001111); S=2 (0100011); B=3 (1100011); U=4 (0110111, 0010111); J=5 (1101111); ILL=7.
- illegal=1, instType=ILL when any of:
  - inst[1:0]!=2'b11
  - unknown opcode
  - R-type fn7 not 0000000, or fn7=0100000 with fn3 not in {000,101}
  - OP-IMM fn3=001 with upper bits nonzero
  - OP-IMM fn3=101 with upper bits not 0 or 0100000
  - Upper bits are inst[31:25] for XLEN=32 and inst[31:26] (6-bit shamt) for XLEN=64.
- Illegal instructions still flow through the pipeline with the flag set. No trap is raised here.

Decomposition:
- Shared package decode_pkg holds:
  - opcode localparams
  - instType enum encodings
  - immediate-format selector constants
- One combinational sub-module, imm_gen (inst, format → XLEN imm), reused later by the compressed-expansion path.
- Classification and illegal checks stay in decode_stage. The handshake/skid logic stays inline.

Test Plan:
- XLEN=32, stream with outReady=1:
  - 0x00848933 → R, rd=18, rs1=9, rs2=8, imm=0
  - 0x10100493 → I, rd=9, imm=0x101
  - 0x0082a223 → S, rs1=5, rs2=8, imm=4
  - 0x014c6463 → B, rs1=24, rs2=20, fn3=6, imm=8
  - each appears 1 cycle after accept
- Jumps/U-type:
  - 0x7ff080e7 → I, imm=0x7FF
  - 0x0000006f → J, imm=0
  - 0x872370b7 → U, imm=0x87237000 (XLEN=64: 0xFFFFFFFF87237000)
  - 0x10000917 → U, imm=0x10000000
- Shift/illegal:
  - 0x41425313 → I, rd=6, rs1=4, illegal=0
  - 0x02000033 (fn7=0000001) → illegal=1, instType=7
  - 0x00000013 with inst[1:0] forced to 00 → illegal=1
- Backpressure (SKID=1): push A, B, C with outReady=0.
  - A sits in the output reg, B in skid, inReady=0 holds C.
  - Then outReady=1 drains A, B, C in order with no bubble and no duplicate.
- Flush:
  - With A and B held, flush=1 together with inValid=1 (C) → next cycle outValid=0, inReady=1, C never emerges.
- Async reset:
  - Assert rst mid-stall, asynchronously to clk → outValid=0 and outputs zeroed immediately.
  - After release, the first new instruction decodes correctly.
